cv32e40p_con_mem_seq: RTL and testbench
=======================================

Name: cv32e40p_con_mem_seq

Overview:
- Memory-access sequencer directly upstream/downstream of the MAC/convolution unit.
- While the MAC unit raises con_active, mp_ri_active or wb23_active, this block issues one-word OBI data-memory transactions, generating tile addresses.
- For reads, it presents the returned words on mem_rdata_o, paired with a 1-based beat count on con_data_cnt_o.
- For writes, it presents a 0-based index on con_data_cnt_o and stores the mem_wdata_i word the MAC unit returns for that index.

Parameters:
- ADDR_W, 32, data-memory address width.
- CNT_W, 32, width of con_data_cnt_o.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- con_active_i  in  1  convolution tile fetch requested (read).
- mp_ri_active_i  in  1  max-pool input fetch requested (read, 4 words).
- wb23_active_i  in  1  2x2 result write-back requested (write, 4 words).
- con_model_i  in  1  0 = full 4x4 tile, 1 = sliding 2-column update; sampled at job start.
- tile_len_i  in  16  con read beats (16 or 8); sampled at job start.
- base_addr_i  in  ADDR_W  tile base byte address; sampled at job start.
- row_stride_i  in  ADDR_W  byte stride between rows; sampled at job start.
- mem_wdata_i  in  32  write word from MAC unit for the current con_data_cnt_o.
- con_data_cnt_o  out  CNT_W  beat counter to MAC unit.
- mem_rdata_o  out  32  registered read word, valid together with con_data_cnt_o.
- busy_o  out  1  job in progress, including drain.
- data_req_o  out  1  OBI request.
- data_gnt_i  in  1  OBI grant.
- data_addr_o  out  ADDR_W  word-aligned address.
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables; always 4'hF when req.
- data_wdata_o  out  32  write data.
- data_rvalid_i  in  1  response valid.
- data_rdata_i  in  32  read data.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - A job starts on the first cycle any active input is 1.
  - Priority con > mp_ri > wb23; lower-priority actives are ignored until return to IDLE.
  - On start: latch job type, config and base; set beat index b=0; go to REQ.
  - First data_req_o is seen the cycle after the active input rises.
- REQ:
  - data_req_o=1; address/we/wdata held stable until data_gnt_i.
  - On gnt: go to WAIT.
- WAIT:
  - On data_rvalid_i, read jobs register data_rdata_i into mem_rdata_o and set con_data_cnt_o=b+1 on the same edge.
  - Writes: rvalid completes the beat and sets con_data_cnt_o=b+1.
  - Then b++. If b < total, go to REQ; else go to HOLD.
  - Only one outstanding transaction at any time.
- Read addressing, with r = b/cols and c = b%cols:
  - con, model 0: cols=4; addr = base + r*stride + c*4; total = tile_len (16).
  - con, model 1: cols=2; addr = base + r*stride + (c+2)*4; total = tile_len (8).
  - mp_ri: cols=2; addr = base + r*stride + c*4; total=4.
- mp_ri terminal: one cycle after the 4th beat, con_data_cnt_o goes from 4 to 5 so the MAC unit exits.
- Write (wb23):
  - con_data_cnt_o=b (0..3) is driven during REQ so the MAC unit's mem_wdata_i is valid.
  - data_wdata_o = mem_wdata_i, registered at REQ entry and held until gnt.
  - Addr = base + (b/2)*stride + (b%2)*4.
  - After the 4th response, con_data_cnt_o=4.
- HOLD:
  - con_data_cnt_o holds its terminal value until the owning active input is 0.
  - Then clear the counter to 0, clear busy_o and go to IDLE.
- Abort (owning active drops before completion):
  - In REQ without gnt: drop req the same cycle, go to IDLE.
  - In WAIT: go to DRAIN, await rvalid, discard the data, and do not update mem_rdata_o or the counter; then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; bits [1:0] are forced to 0.
- Async reset mid-transaction returns to IDLE immediately; no drain.

Optional Feature:
- Macro CON_MEM_SEQ_PERF_EN.
- When defined:
  - Add output stall_cnt_o (32) counting cycles in REQ with data_gnt_i=0 or in WAIT with data_rvalid_i=0.
  - Add input stall_clr_i, a synchronous clear that wins over increment.
  - The counter saturates at 32'hFFFFFFFF and resets to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- con model 0, base=0x1000, stride=0x40, tile_len=16, gnt/rvalid zero-wait -> 16 reads at 0x1000,0x1004,0x1008,0x100C,0x1040..0x10CC; con_data_cnt_o steps 1..16 each paired with rdata; holds at 16 until con_active_i=0, then 0.
- con model 1, base=0x2000, stride=0x20, tile_len=8 -> addresses 0x2008,0x200C,0x2028,0x202C,0x2048,0x204C,0x2068,0x206C; cnt 1..8.
- wb23, base=0x3000, stride=0x10, mem_wdata_i=0x11,0x22,0x33,0x44 for cnt 0..3, gnt delayed 2 cycles each -> writes at 0x3000,0x3004,0x3010,0x3014 with matching data held through stall; cnt ends at 4.
- mp_ri, base=0x4000, stride=0x8 -> reads 0x4000,0x4004,0x4008,0x400C; cnt 1..4 then 5; returns to 0 when mp_ri_active_i falls.
- Abort: drop con_active_i after gnt of beat 3 with rvalid 3 cycles late -> DRAIN; mem_rdata_o and cnt stay at beat-2 values; busy_o falls after rvalid. Separately, rst_n pulse mid-REQ -> data_req_o=0 asynchronously.
- Simultaneous con_active_i and wb23_active_i rising -> con job served first; with CON_MEM_SEQ_PERF_EN, 2-cycle gnt stalls on 16 beats give stall_cnt_o=32.

Source files
------------

// File: rtl/cv32e40p_con_mem_seq.sv
// OBI data-memory sequencer feeding/draining the MAC unit: tile reads, max-pool reads, 2x2 write-back.
// Optional stall counter enabled by defining CON_MEM_SEQ_PERF_EN.
module cv32e40p_con_mem_seq #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              con_active_i,
   input  logic              mp_ri_active_i,
   input  logic              wb23_active_i,
   input  logic              con_model_i,
   input  logic [15:0]       tile_len_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] row_stride_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [CNT_W-1:0]  con_data_cnt_o,
   output logic [31:0]       mem_rdata_o,
   output logic              busy_o,
`ifdef CON_MEM_SEQ_PERF_EN
   input  logic              stall_clr_i,
   output logic [31:0]       stall_cnt_o,
`endif
   output logic              data_req_o,
   input  logic              data_gnt_i,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
   typedef enum logic [1:0] {JOB_CON, JOB_MP, JOB_WB} job_t;

   state_t            state_reg, state_next;
   job_t              job_reg;
   logic              model_reg;
   logic [15:0]       total_reg, beat_reg;
   logic [ADDR_W-1:0] base_reg, stride_reg, row_off_reg;
   logic [1:0]        col_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [31:0]       rdata_reg, wdata_reg;
   logic              wdata_held_reg;

   logic              own_active, start, beat_done, last_col, slide;
   logic [15:0]       beat_inc;
   logic [2:0]        col_word;
   logic [ADDR_W-1:0] addr_sum;

   always_comb begin
      own_active = 1'b0;
      case (job_reg)
         JOB_CON: own_active = con_active_i;
         JOB_MP:  own_active = mp_ri_active_i;
         default: own_active = wb23_active_i;
      endcase
   end

   // Row offset is accumulated per row instead of multiplying beat/cols by the stride.
   assign start     = con_active_i | mp_ri_active_i | wb23_active_i;
   assign slide     = (job_reg == JOB_CON) && model_reg;
   assign last_col  = (job_reg == JOB_CON && !model_reg) ? (col_reg == 2'd3) : (col_reg == 2'd1);
   assign col_word  = {1'b0, col_reg} + (slide ? 3'd2 : 3'd0);
   assign addr_sum  = base_reg + row_off_reg + ADDR_W'({col_word, 2'b00});
   assign beat_inc  = beat_reg + 16'd1;
   assign beat_done = (state_reg == WAIT) && data_rvalid_i && own_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (start) state_next = REQ;
         REQ: begin
            if (!own_active)     state_next = IDLE;
            else if (data_gnt_i) state_next = WAIT;
         end
         WAIT: begin
            if (data_rvalid_i) begin
               if (!own_active)              state_next = IDLE;
               else if (beat_inc < total_reg) state_next = REQ;
               else                           state_next = HOLD;
            end else if (!own_active) begin
               state_next = DRAIN;
            end
         end
         HOLD:  if (!own_active) state_next = IDLE;
         DRAIN: if (data_rvalid_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      data_req_o   = (state_reg == REQ) && own_active;
      data_addr_o  = data_req_o ? (addr_sum & ~ADDR_W'(3)) : '0;
      data_we_o    = data_req_o && (job_reg == JOB_WB);
      data_be_o    = data_req_o ? 4'hF : 4'h0;
      // First REQ cycle forwards the MAC word directly; later stall cycles replay the captured copy.
      data_wdata_o = data_we_o ? (wdata_held_reg ? wdata_reg : mem_wdata_i) : 32'h0;
      busy_o       = (state_reg != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_reg        <= JOB_CON;
         model_reg      <= 1'b0;
         total_reg      <= '0;
         beat_reg       <= '0;
         base_reg       <= '0;
         stride_reg     <= '0;
         row_off_reg    <= '0;
         col_reg        <= '0;
         cnt_reg        <= '0;
         rdata_reg      <= '0;
         wdata_reg      <= '0;
         wdata_held_reg <= 1'b0;
      end else begin
         wdata_held_reg <= (state_reg == REQ) && (state_next == REQ);
         if (state_reg == REQ && !wdata_held_reg) wdata_reg <= mem_wdata_i;
         case (state_reg)
            IDLE: if (start) begin
               if (con_active_i) begin
                  job_reg   <= JOB_CON;
                  total_reg <= tile_len_i;
               end else if (mp_ri_active_i) begin
                  job_reg   <= JOB_MP;
                  total_reg <= 16'd4;
               end else begin
                  job_reg   <= JOB_WB;
                  total_reg <= 16'd4;
               end
               model_reg   <= con_model_i;
               base_reg    <= base_addr_i;
               stride_reg  <= row_stride_i;
               beat_reg    <= '0;
               col_reg     <= '0;
               row_off_reg <= '0;
               cnt_reg     <= '0;
            end
            WAIT: if (beat_done) begin
               beat_reg <= beat_inc;
               cnt_reg  <= CNT_W'(beat_inc);
               if (job_reg != JOB_WB) rdata_reg <= data_rdata_i;
               if (last_col) begin
                  col_reg     <= '0;
                  row_off_reg <= row_off_reg + stride_reg;
               end else begin
                  col_reg <= col_reg + 2'd1;
               end
            end
            HOLD: begin
               if (!own_active)
                  cnt_reg <= '0;
               else if (job_reg == JOB_MP && cnt_reg == CNT_W'(total_reg))
                  cnt_reg <= cnt_reg + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign con_data_cnt_o = cnt_reg;
   assign mem_rdata_o    = rdata_reg;

`ifdef CON_MEM_SEQ_PERF_EN
   logic [31:0] stall_reg;
   logic        stall_evt;

   assign stall_evt = ((state_reg == REQ) && !data_gnt_i) || ((state_reg == WAIT) && !data_rvalid_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   stall_reg <= '0;
      else if (stall_clr_i)                         stall_reg <= '0;
      else if (stall_evt && stall_reg != 32'hFFFF_FFFF) stall_reg <= stall_reg + 32'd1;
   end

   assign stall_cnt_o = stall_reg;
`endif

endmodule

// File: tb/tb_cv32e40p_con_mem_seq.sv
// Scoreboard bench: stimulus queues expected bus transactions and counter steps; a monitor checks them.
`timescale 1ns/1ps
module tb_cv32e40p_con_mem_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        con_active_i, mp_ri_active_i, wb23_active_i, con_model_i;
   logic [15:0] tile_len_i;
   logic [31:0] base_addr_i, row_stride_i, mem_wdata_i;
   logic [31:0] con_data_cnt_o, mem_rdata_o;
   logic        busy_o, data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic [3:0]  data_be_o;
`ifdef CON_MEM_SEQ_PERF_EN
   logic        stall_clr_i;
   logic [31:0] stall_cnt_o;
`endif

   always #5 clk = ~clk;

   cv32e40p_con_mem_seq #(.ADDR_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .con_active_i(con_active_i), .mp_ri_active_i(mp_ri_active_i), .wb23_active_i(wb23_active_i),
      .con_model_i(con_model_i), .tile_len_i(tile_len_i),
      .base_addr_i(base_addr_i), .row_stride_i(row_stride_i), .mem_wdata_i(mem_wdata_i),
      .con_data_cnt_o(con_data_cnt_o), .mem_rdata_o(mem_rdata_o), .busy_o(busy_o),
`ifdef CON_MEM_SEQ_PERF_EN
      .stall_clr_i(stall_clr_i), .stall_cnt_o(stall_cnt_o),
`endif
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
   );

   typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
   typedef struct packed { logic [31:0] cnt; logic chk; logic [31:0] rdata; } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   gnt_delay = 0;
   int   late_at = -1;
   int   late_delay = 0;
   int   hs_count = 0;

   logic [31:0] wtbl [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   // MAC unit model: returns the write word selected by the beat index.
   always_comb begin
      mem_wdata_i = 32'h0;
      if (con_data_cnt_o < 32'd4) mem_wdata_i = wtbl[con_data_cnt_o[1:0]];
   end

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_read(input logic [31:0] addr, input logic [31:0] cnt);
      req_q.push_back('{addr: addr, we: 1'b0, wdata: 32'h0});
      rsp_q.push_back('{cnt: cnt, chk: 1'b1, rdata: rd_val(addr)});
   endtask

   task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] cnt);
      req_q.push_back('{addr: addr, we: 1'b1, wdata: data});
      rsp_q.push_back('{cnt: cnt, chk: 1'b0, rdata: 32'h0});
   endtask

   task automatic push_cnt(input logic [31:0] cnt);
      rsp_q.push_back('{cnt: cnt, chk: 1'b0, rdata: 32'h0});
   endtask

   task automatic wait_cnt_val(input logic [31:0] v, input int limit, input string name);
      int n = 0;
      while (con_data_cnt_o !== v && n < limit) begin
         cycles(1);
         n++;
      end
      check(name, con_data_cnt_o, v);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while (busy_o !== 1'b0 && n < limit) begin
         cycles(1);
         n++;
      end
      check(name, {31'h0, busy_o}, 32'h0);
   endtask

   // Memory slave: gnt after gnt_delay requesting cycles, rvalid the cycle after gnt unless delayed.
   initial begin : slave
      int          wait_cnt, pend;
      logic        hs, rq;
      logic [31:0] hs_addr, pend_addr;
      wait_cnt = 0; pend = 0; pend_addr = 0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         rq      = data_req_o;
         hs      = data_req_o && data_gnt_i;
         hs_addr = data_addr_o;
         if (hs) hs_count++;
         @(posedge clk);
         #1;
         data_rvalid_i = 1'b0;
         if (hs) begin
            wait_cnt = 0;
            pend = (hs_count == late_at) ? late_delay : 0;
            if (pend == 0) begin
               data_rvalid_i = 1'b1;
               data_rdata_i  = rd_val(hs_addr);
            end else begin
               pend_addr = hs_addr;
            end
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  data_rvalid_i = 1'b1;
                  data_rdata_i  = rd_val(pend_addr);
               end
            end
            if (rq) wait_cnt++;
            else    wait_cnt = 0;
         end
         data_gnt_i = (wait_cnt >= gnt_delay);
      end
   end

   initial begin : monitor
      logic [31:0] prev_cnt;
      req_t        er;
      rsp_t        es;
      prev_cnt = 32'h0;
      forever begin
         @(negedge clk);
         if (data_req_o && data_we_o && req_q.size() > 0)
            check("wdata_stable", data_wdata_o, req_q[0].wdata);
         if (data_req_o && data_gnt_i) begin
            $display("txn addr=%h we=%0b wdata=%h cnt=%0d", data_addr_o, data_we_o, data_wdata_o, con_data_cnt_o);
            if (req_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_req: got addr %h expected no request", data_addr_o);
            end else begin
               er = req_q.pop_front();
               check("req_addr", data_addr_o, er.addr);
               check("req_we", {31'h0, data_we_o}, {31'h0, er.we});
               check("req_be", {28'h0, data_be_o}, 32'hF);
               if (er.we) check("req_wdata", data_wdata_o, er.wdata);
            end
         end
         if (con_data_cnt_o !== prev_cnt) begin
            $display("cnt %0d -> %0d rdata=%h", prev_cnt, con_data_cnt_o, mem_rdata_o);
            if (rsp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_cnt: got %0d expected no change from %0d", con_data_cnt_o, prev_cnt);
            end else begin
               es = rsp_q.pop_front();
               check("cnt_step", con_data_cnt_o, es.cnt);
               if (es.chk) check("rdata", mem_rdata_o, es.rdata);
            end
            prev_cnt = con_data_cnt_o;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [31:0] a_m1 [8] = '{32'h2008, 32'h200C, 32'h2028, 32'h202C, 32'h2048, 32'h204C, 32'h2068, 32'h206C};
      logic [31:0] a_wb [4] = '{32'h3000, 32'h3004, 32'h3010, 32'h3014};
      logic [31:0] a_mp [4] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
      logic [31:0] a_wb2 [4] = '{32'h8000, 32'h8004, 32'h8010, 32'h8014};
      int n;
      rst_n = 1'b0;
      con_active_i = 0; mp_ri_active_i = 0; wb23_active_i = 0; con_model_i = 0;
      tile_len_i = 16'd0; base_addr_i = 0; row_stride_i = 0;
`ifdef CON_MEM_SEQ_PERF_EN
      stall_clr_i = 1'b0;
`endif
      cycles(3);
      check("rst_req", {31'h0, data_req_o}, 32'h0);
      check("rst_busy", {31'h0, busy_o}, 32'h0);
      check("rst_cnt", con_data_cnt_o, 32'h0);
      check("rst_rdata", mem_rdata_o, 32'h0);
      check("rst_addr", data_addr_o, 32'h0);
      check("rst_be", {28'h0, data_be_o}, 32'h0);
      rst_n = 1'b1;
      cycles(2);

      // con, full 4x4 tile, zero-wait memory
      for (int b = 0; b < 16; b++) push_read(32'h1000 + (b / 4) * 32'h40 + (b % 4) * 4, b + 1);
      push_cnt(0);
      con_model_i = 0; tile_len_i = 16'd16; base_addr_i = 32'h1000; row_stride_i = 32'h40;
      con_active_i = 1;
      #1 check("no_req_same_cycle", {31'h0, data_req_o}, 32'h0);
      cycles(1);
      check("first_req_latency", {31'h0, data_req_o}, 32'h1);
      wait_cnt_val(16, 100, "con0_done");
      cycles(4);
      check("con0_hold_cnt", con_data_cnt_o, 32'd16);
      check("con0_hold_busy", {31'h0, busy_o}, 32'h1);
      con_active_i = 0;
      wait_idle(10, "con0_idle");
      check("con0_cleared", con_data_cnt_o, 32'h0);

      // con, sliding 2-column update
      for (int b = 0; b < 8; b++) push_read(a_m1[b], b + 1);
      push_cnt(0);
      con_model_i = 1; tile_len_i = 16'd8; base_addr_i = 32'h2000; row_stride_i = 32'h20;
      con_active_i = 1;
      wait_cnt_val(8, 100, "con1_done");
      cycles(2);
      con_active_i = 0;
      wait_idle(10, "con1_idle");

      // wb23 write-back with 2-cycle grant stalls
      gnt_delay = 2;
      for (int b = 0; b < 4; b++) push_write(a_wb[b], wtbl[b], b + 1);
      push_cnt(0);
      base_addr_i = 32'h3000; row_stride_i = 32'h10;
      wb23_active_i = 1;
      wait_cnt_val(4, 100, "wb_done");
      cycles(2);
      check("wb_hold_cnt", con_data_cnt_o, 32'd4);
      wb23_active_i = 0;
      wait_idle(10, "wb_idle");

      // mp_ri: four reads, then terminal step 4 -> 5
      gnt_delay = 0;
      for (int b = 0; b < 4; b++) push_read(a_mp[b], b + 1);
      push_cnt(5);
      push_cnt(0);
      base_addr_i = 32'h4000; row_stride_i = 32'h8;
      mp_ri_active_i = 1;
      wait_cnt_val(4, 100, "mp_beats");
      cycles(1);
      check("mp_terminal", con_data_cnt_o, 32'd5);
      cycles(2);
      check("mp_terminal_hold", con_data_cnt_o, 32'd5);
      mp_ri_active_i = 0;
      wait_idle(10, "mp_idle");

      // abort in WAIT: beat 3 response arrives 3 cycles late and is discarded
      late_at = hs_count + 3; late_delay = 3;
      push_read(32'h5000, 1);
      push_read(32'h5004, 2);
      req_q.push_back('{addr: 32'h5008, we: 1'b0, wdata: 32'h0});
      con_model_i = 0; tile_len_i = 16'd16; base_addr_i = 32'h5000; row_stride_i = 32'h40;
      con_active_i = 1;
      n = 0;
      while (hs_count < late_at && n < 50) begin
         cycles(1);
         n++;
      end
      check("abort_third_gnt", hs_count, late_at);
      con_active_i = 0;
      cycles(1);
      check("drain_busy", {31'h0, busy_o}, 32'h1);
      check("drain_cnt", con_data_cnt_o, 32'd2);
      check("drain_rdata", mem_rdata_o, rd_val(32'h5004));
      wait_idle(20, "drain_idle");
      check("post_drain_cnt", con_data_cnt_o, 32'd2);
      check("post_drain_rdata", mem_rdata_o, rd_val(32'h5004));
      late_at = -1;

      // asynchronous reset in REQ
      gnt_delay = 5;
      push_cnt(0);
      base_addr_i = 32'h6000;
      con_active_i = 1;
      cycles(1);
      check("rst_test_req", {31'h0, data_req_o}, 32'h1);
      check("rst_test_addr", data_addr_o, 32'h6000);
      #1 rst_n = 1'b0;
      #1 check("async_rst_req", {31'h0, data_req_o}, 32'h0);
      check("async_rst_busy", {31'h0, busy_o}, 32'h0);
      con_active_i = 0;
      cycles(1);
      rst_n = 1'b1;
      cycles(1);

      // simultaneous con and wb23: con first, wb23 once con returns to IDLE
      gnt_delay = 2;
`ifdef CON_MEM_SEQ_PERF_EN
      stall_clr_i = 1'b1;
      cycles(1);
      stall_clr_i = 1'b0;
      check("stall_clear", stall_cnt_o, 32'h0);
`endif
      for (int b = 0; b < 16; b++) push_read(32'h7000 + (b / 4) * 32'h40 + (b % 4) * 4, b + 1);
      push_cnt(0);
      for (int b = 0; b < 4; b++) push_write(a_wb2[b], wtbl[b], b + 1);
      push_cnt(0);
      con_model_i = 0; tile_len_i = 16'd16; base_addr_i = 32'h7000; row_stride_i = 32'h40;
      con_active_i = 1; wb23_active_i = 1;
      wait_cnt_val(16, 300, "prio_con_done");
      cycles(1);
`ifdef CON_MEM_SEQ_PERF_EN
      check("stall_count", stall_cnt_o, 32'd32);
`endif
      base_addr_i = 32'h8000; row_stride_i = 32'h10;
      cycles(1);
      con_active_i = 0;
      wait_cnt_val(4, 200, "prio_wb_done");
      cycles(2);
      wb23_active_i = 0;
      wait_idle(10, "prio_idle");
      cycles(3);

      check("req_queue_empty", req_q.size(), 32'h0);
      check("rsp_queue_empty", rsp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
